// File: rtl/asym_fifo_pkg.sv
// Width helpers and derived-parameter functions for the asymmetric-width FIFO.
// Shared by the FIFO RTL and its benches.
package asym_fifo_pkg;

   typedef enum logic [1:0] {
      MODE_EQUAL    = 2'd0,
      MODE_UPSIZE   = 2'd1,
      MODE_DOWNSIZE = 2'd2
   } width_mode_e;

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int f_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit f_is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic int f_ratio(input int wr_w, input int rd_w);
      return f_max(wr_w, rd_w) / f_min(wr_w, rd_w);
   endfunction

   // The wide side must be an exact power-of-2 multiple of the narrow side.
   function automatic bit f_widths_ok(input int wr_w, input int rd_w);
      return (wr_w > 0) && (rd_w > 0) &&
             ((f_max(wr_w, rd_w) % f_min(wr_w, rd_w)) == 0) &&
             f_is_pow2(f_ratio(wr_w, rd_w));
   endfunction

   function automatic int f_units(input int side_w, input int wr_w, input int rd_w);
      return side_w / f_min(wr_w, rd_w);
   endfunction

   function automatic int f_cnt_w(input int depth_lg2, input int side_w,
                                  input int wr_w, input int rd_w);
      return $clog2(((1 << depth_lg2) * f_max(wr_w, rd_w)) / side_w) + 1;
   endfunction

   function automatic width_mode_e f_mode(input int wr_w, input int rd_w);
      if (wr_w < rd_w) return MODE_UPSIZE;
      if (wr_w > rd_w) return MODE_DOWNSIZE;
      return MODE_EQUAL;
   endfunction

endpackage

// File: rtl/asym_fifo_ptr.sv
// Unit-granular write/read pointers with wrap bit, occupancy counts and registered
// full/empty/almost-full flags derived from the next-state pointers.
module asym_fifo_ptr
   import asym_fifo_pkg::*;
#(
   parameter int  DEPTH_LG2 = 4,
   parameter int  WR_WIDTH  = 8,
   parameter int  RD_WIDTH  = 32,
   parameter int  AF_LEVEL  = 12,
   localparam int RATIO     = f_ratio(WR_WIDTH, RD_WIDTH),
   localparam int LANE_W    = f_max($clog2(RATIO), 1),
   localparam int WR_CNT_W  = f_cnt_w(DEPTH_LG2, WR_WIDTH, WR_WIDTH, RD_WIDTH),
   localparam int RD_CNT_W  = f_cnt_w(DEPTH_LG2, RD_WIDTH, WR_WIDTH, RD_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_acc_i,
   input  logic                 rd_acc_i,
   input  logic                 flush_req_i,
   output logic [DEPTH_LG2-1:0] wr_addr_o,
   output logic [LANE_W-1:0]    wr_lane_o,
   output logic [DEPTH_LG2-1:0] rd_addr_o,
   output logic [LANE_W-1:0]    rd_lane_o,
   output logic                 pad_o,
   output logic [WR_CNT_W-1:0]  wrusedw_o,
   output logic [RD_CNT_W-1:0]  rdusedw_o,
   output logic                 wrfull_o,
   output logic                 wralmost_full_o,
   output logic                 rdempty_o
);

   localparam int WR_UNITS    = f_units(WR_WIDTH, WR_WIDTH, RD_WIDTH);
   localparam int RD_UNITS    = f_units(RD_WIDTH, WR_WIDTH, RD_WIDTH);
   localparam int TOTAL_UNITS = RATIO << DEPTH_LG2;
   localparam int PTR_W       = $clog2(TOTAL_UNITS) + 1;
   localparam int LG_RATIO    = $clog2(RATIO);
   localparam int LG_WR       = $clog2(WR_UNITS);
   localparam int LG_RD       = $clog2(RD_UNITS);

   logic [PTR_W-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d, used_q, used_d, wr_step;
   logic             wrfull_q, wrfull_d, af_q, af_d, rdempty_q, rdempty_d;

   function automatic logic [LANE_W-1:0] lane_of(input logic [PTR_W-1:0] p);
      return LANE_W'(p & PTR_W'(RATIO - 1));
   endfunction

   function automatic logic [DEPTH_LG2-1:0] addr_of(input logic [PTR_W-1:0] p);
      return DEPTH_LG2'(p >> LG_RATIO);
   endfunction

   // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
   always_comb begin
      wr_step   = wrptr_q + (wr_acc_i ? PTR_W'(WR_UNITS) : '0);
      pad_o     = flush_req_i && (lane_of(wr_step) != '0);
      wrptr_d   = wr_step;
      if (pad_o) wrptr_d = (wr_step | PTR_W'(RATIO - 1)) + PTR_W'(1);
      rdptr_d   = rdptr_q + (rd_acc_i ? PTR_W'(RD_UNITS) : '0);
      used_d    = wrptr_d - rdptr_d;
      wrfull_d  = (PTR_W'(TOTAL_UNITS) - used_d) < PTR_W'(WR_UNITS);
      rdempty_d = used_d < PTR_W'(RD_UNITS);
      af_d      = (used_d >> LG_WR) >= PTR_W'(AF_LEVEL);
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrptr_q   <= '0;
         rdptr_q   <= '0;
         used_q    <= '0;
         wrfull_q  <= 1'b0;
         af_q      <= 1'b0;
         rdempty_q <= 1'b1;
      end else begin
         wrptr_q   <= wrptr_d;
         rdptr_q   <= rdptr_d;
         used_q    <= used_d;
         wrfull_q  <= wrfull_d;
         af_q      <= af_d;
         rdempty_q <= rdempty_d;
      end
   end

   assign wr_addr_o       = addr_of(wrptr_q);
   assign wr_lane_o       = lane_of(wrptr_q);
   assign rd_addr_o       = addr_of(rdptr_q);
   assign rd_lane_o       = lane_of(rdptr_q);
   assign wrusedw_o       = WR_CNT_W'(used_q >> LG_WR);
   assign rdusedw_o       = RD_CNT_W'(used_q >> LG_RD);
   assign wrfull_o        = wrfull_q;
   assign wralmost_full_o = af_q;
   assign rdempty_o       = rdempty_q;

endmodule

// File: rtl/asym_width_fifo.sv
// Single-clock FIFO with independent write/read widths (integer power-of-2 ratio, LSB lane first).
// Optional partial-word flush for upsize builds: define ASYM_FIFO_FLUSH_EN.
module asym_width_fifo
   import asym_fifo_pkg::*;
#(
   parameter int  DEPTH_LG2 = 4,
   parameter int  WR_WIDTH  = 8,
   parameter int  RD_WIDTH  = 32,
   parameter int  AF_LEVEL  = 12,
   parameter int  RST_MEM   = 0,
   localparam int WR_CNT_W  = f_cnt_w(DEPTH_LG2, WR_WIDTH, WR_WIDTH, RD_WIDTH),
   localparam int RD_CNT_W  = f_cnt_w(DEPTH_LG2, RD_WIDTH, WR_WIDTH, RD_WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wrreq_i,
   input  logic [WR_WIDTH-1:0] wdata_i,
   output logic [WR_CNT_W-1:0] wrusedw_o,
   output logic                wrfull_o,
   output logic                wralmost_full_o,
   output logic                ovf_o,
   input  logic                rdreq_i,
   output logic [RD_WIDTH-1:0] rdata_o,
   output logic [RD_CNT_W-1:0] rdusedw_o,
   output logic                rdempty_o,
   output logic                udf_o,
   input  logic                flush_i
);

   localparam int MAX_W    = f_max(WR_WIDTH, RD_WIDTH);
   localparam int MIN_W    = f_min(WR_WIDTH, RD_WIDTH);
   localparam int RATIO    = f_ratio(WR_WIDTH, RD_WIDTH);
   localparam int LANE_W   = f_max($clog2(RATIO), 1);
   localparam int WR_UNITS = f_units(WR_WIDTH, WR_WIDTH, RD_WIDTH);
   localparam int DEPTH    = 1 << DEPTH_LG2;
   localparam int CAP_WR   = (DEPTH * MAX_W) / WR_WIDTH;

   if (!f_widths_ok(WR_WIDTH, RD_WIDTH)) begin : g_bad_ratio
      $error("asym_width_fifo: max/min width ratio must be an integer power of 2");
   end
   if (AF_LEVEL > CAP_WR) begin : g_bad_af
      $error("asym_width_fifo: AF_LEVEL exceeds capacity in write words");
   end

   logic                 wr_acc, rd_acc, flush_req, pad;
   logic [DEPTH_LG2-1:0] wr_addr, rd_addr;
   logic [LANE_W-1:0]    wr_lane, rd_lane;
   logic                 ovf_q, ovf_d, udf_q, udf_d;
   logic [MAX_W-1:0]     mem_q [DEPTH];
   logic [MAX_W-1:0]     mem_wdata;
   logic                 mem_we;

   assign wr_acc = wrreq_i & ~wrfull_o;
   assign rd_acc = rdreq_i & ~rdempty_o;

`ifdef ASYM_FIFO_FLUSH_EN
   localparam width_mode_e MODE = f_mode(WR_WIDTH, RD_WIDTH);
   assign flush_req = flush_i && (MODE == MODE_UPSIZE);
`else
   logic unused_flush;
   assign unused_flush = flush_i;
   assign flush_req    = 1'b0;
`endif

   asym_fifo_ptr #(
      .DEPTH_LG2 (DEPTH_LG2),
      .WR_WIDTH  (WR_WIDTH),
      .RD_WIDTH  (RD_WIDTH),
      .AF_LEVEL  (AF_LEVEL)
   ) u_ptr (
      .clk             (clk),
      .rst             (rst),
      .wr_acc_i        (wr_acc),
      .rd_acc_i        (rd_acc),
      .flush_req_i     (flush_req),
      .wr_addr_o       (wr_addr),
      .wr_lane_o       (wr_lane),
      .rd_addr_o       (rd_addr),
      .rd_lane_o       (rd_lane),
      .pad_o           (pad),
      .wrusedw_o       (wrusedw_o),
      .rdusedw_o       (rdusedw_o),
      .wrfull_o        (wrfull_o),
      .wralmost_full_o (wralmost_full_o),
      .rdempty_o       (rdempty_o)
   );

   // Merge the write lanes into the addressed word; flush padding zero-fills the lanes after them.
   always_comb begin
      mem_we    = wr_acc | pad;
      mem_wdata = mem_q[wr_addr];
      for (int l = 0; l < RATIO; l++) begin
         if (wr_acc && (l >= int'(wr_lane)) && (l < int'(wr_lane) + WR_UNITS)) begin
            mem_wdata[l*MIN_W +: MIN_W] = wdata_i[(l - int'(wr_lane))*MIN_W +: MIN_W];
         end else if (pad && (l >= int'(wr_lane))) begin
            mem_wdata[l*MIN_W +: MIN_W] = '0;
         end
      end
   end

   // NOTE: storage takes a reset only when RST_MEM asks for it; otherwise it stays a plain RAM.
   if (RST_MEM != 0) begin : g_mem_rst
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
         end else if (mem_we) begin
            mem_q[wr_addr] <= mem_wdata;
         end
      end
   end else begin : g_mem_norst
      always_ff @(posedge clk) begin
         if (mem_we) mem_q[wr_addr] <= mem_wdata;
      end
   end

   assign rdata_o = mem_q[rd_addr][int'(rd_lane)*MIN_W +: RD_WIDTH];

   always_comb begin
      ovf_d = ovf_q | (wrreq_i & wrfull_o);
      udf_d = udf_q | (rdreq_i & rdempty_o);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf_o = ovf_q;
   assign udf_o = udf_q;

endmodule

// File: tb/tb_asym_width_fifo.sv
// Bench: an 8->32 upsize FIFO and a 32->8 downsize FIFO driven side by side and compared
// every cycle against byte-queue models, plus literal checks of the documented scenarios.
module tb_asym_width_fifo;
   import asym_fifo_pkg::*;

   localparam int UP_WC = f_cnt_w(2, 8, 8, 32);
   localparam int UP_RC = f_cnt_w(2, 32, 8, 32);
   localparam int DN_WC = f_cnt_w(2, 32, 32, 8);
   localparam int DN_RC = f_cnt_w(2, 8, 32, 8);
   localparam int CAP_UNITS = 16;
`ifdef ASYM_FIFO_FLUSH_EN
   localparam bit FLUSH_ON = 1'b1;
`else
   localparam bit FLUSH_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;

   logic             up_wrreq = 1'b0, up_rdreq = 1'b0;
   logic [7:0]       up_wdata = '0;
   logic [31:0]      up_rdata;
   logic [UP_WC-1:0] up_wrusedw;
   logic [UP_RC-1:0] up_rdusedw;
   logic             up_wrfull, up_af, up_ovf, up_rdempty, up_udf;

   logic             dn_wrreq = 1'b0, dn_rdreq = 1'b0;
   logic [31:0]      dn_wdata = '0;
   logic [7:0]       dn_rdata;
   logic [DN_WC-1:0] dn_wrusedw;
   logic [DN_RC-1:0] dn_rdusedw;
   logic             dn_wrfull, dn_af, dn_ovf, dn_rdempty, dn_udf;

   always #5 clk = ~clk;

   asym_width_fifo #(
      .DEPTH_LG2(2), .WR_WIDTH(8), .RD_WIDTH(32), .AF_LEVEL(12), .RST_MEM(0)
   ) u_up (
      .clk(clk), .rst(rst), .wrreq_i(up_wrreq), .wdata_i(up_wdata),
      .wrusedw_o(up_wrusedw), .wrfull_o(up_wrfull), .wralmost_full_o(up_af), .ovf_o(up_ovf),
      .rdreq_i(up_rdreq), .rdata_o(up_rdata), .rdusedw_o(up_rdusedw), .rdempty_o(up_rdempty),
      .udf_o(up_udf), .flush_i(flush)
   );

   asym_width_fifo #(
      .DEPTH_LG2(2), .WR_WIDTH(32), .RD_WIDTH(8), .AF_LEVEL(3), .RST_MEM(1)
   ) u_dn (
      .clk(clk), .rst(rst), .wrreq_i(dn_wrreq), .wdata_i(dn_wdata),
      .wrusedw_o(dn_wrusedw), .wrfull_o(dn_wrfull), .wralmost_full_o(dn_af), .ovf_o(dn_ovf),
      .rdreq_i(dn_rdreq), .rdata_o(dn_rdata), .rdusedw_o(dn_rdusedw), .rdempty_o(dn_rdempty),
      .udf_o(dn_udf), .flush_i(flush)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored bytes in arrival order (LSB lane first), sticky error flags.
   logic [7:0] up_q[$];
   logic [7:0] dn_q[$];
   bit m_up_ovf, m_up_udf, m_dn_ovf, m_dn_udf;
   bit chk_en = 1'b0;

   task automatic model_reset();
      up_q.delete();
      dn_q.delete();
      m_up_ovf = 1'b0; m_up_udf = 1'b0;
      m_dn_ovf = 1'b0; m_dn_udf = 1'b0;
   endtask

   task automatic model_up(input bit wr, input logic [7:0] d, input bit rd, input bit fl);
      int sz;
      sz = up_q.size();
      if (wr && (CAP_UNITS - sz) < 1) m_up_ovf = 1'b1;
      if (rd && sz < 4) m_up_udf = 1'b1;
      if (rd && sz >= 4) repeat (4) void'(up_q.pop_front());
      if (wr && (CAP_UNITS - sz) >= 1) up_q.push_back(d);
      if (FLUSH_ON && fl) while ((up_q.size() % 4) != 0) up_q.push_back(8'h00);
   endtask

   task automatic model_dn(input bit wr, input logic [31:0] d, input bit rd);
      int sz;
      sz = dn_q.size();
      if (wr && (CAP_UNITS - sz) < 4) m_dn_ovf = 1'b1;
      if (rd && sz < 1) m_dn_udf = 1'b1;
      if (rd && sz >= 1) void'(dn_q.pop_front());
      if (wr && (CAP_UNITS - sz) >= 4)
         for (int i = 0; i < 4; i++) dn_q.push_back(d[8*i +: 8]);
   endtask

   // Per-cycle comparison of both DUTs against the model.
   int us, ds;
   always @(negedge clk) begin
      if (chk_en) begin
         us = up_q.size();
         ds = dn_q.size();
         check("up_wrusedw", 32'(up_wrusedw), 32'(us));
         check("up_rdusedw", 32'(up_rdusedw), 32'(us / 4));
         check("up_wrfull",  32'(up_wrfull),  32'((CAP_UNITS - us) < 1));
         check("up_rdempty", 32'(up_rdempty), 32'(us < 4));
         check("up_af",      32'(up_af),      32'(us >= 12));
         check("up_ovf",     32'(up_ovf),     32'(m_up_ovf));
         check("up_udf",     32'(up_udf),     32'(m_up_udf));
         if (us >= 4) check("up_rdata", up_rdata, {up_q[3], up_q[2], up_q[1], up_q[0]});
         check("dn_wrusedw", 32'(dn_wrusedw), 32'(ds / 4));
         check("dn_rdusedw", 32'(dn_rdusedw), 32'(ds));
         check("dn_wrfull",  32'(dn_wrfull),  32'((CAP_UNITS - ds) < 4));
         check("dn_rdempty", 32'(dn_rdempty), 32'(ds < 1));
         check("dn_af",      32'(dn_af),      32'((ds / 4) >= 3));
         check("dn_ovf",     32'(dn_ovf),     32'(m_dn_ovf));
         check("dn_udf",     32'(dn_udf),     32'(m_dn_udf));
         if (ds >= 1) check("dn_rdata", 32'(dn_rdata), 32'(dn_q[0]));
      end
   end

   // One clock of stimulus: drive at negedge, update the model after the edge, return at negedge.
   task automatic step(input bit uw, input logic [7:0] ud, input bit ur, input bit fl,
                       input bit dw, input logic [31:0] dd, input bit dr);
      up_wrreq = uw; up_wdata = ud; up_rdreq = ur; flush = fl;
      dn_wrreq = dw; dn_wdata = dd; dn_rdreq = dr;
      @(posedge clk);
      model_up(uw, ud, ur, fl);
      model_dn(dw, dd, dr);
      @(negedge clk);
   endtask

   task automatic up_wr(input logic [7:0] d);  step(1'b1, d, 1'b0, 1'b0, 1'b0, '0, 1'b0); endtask
   task automatic up_rd();                     step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0); endtask
   task automatic dn_wr(input logic [31:0] d); step(1'b0, '0, 1'b0, 1'b0, 1'b1, d, 1'b0);  endtask
   task automatic dn_rd();                     step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1); endtask

   logic [7:0] dn_exp [4];

   initial begin
      model_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_up_rdempty", 32'(up_rdempty), 32'd1);
      check("rst_up_wrfull",  32'(up_wrfull),  32'd0);
      check("rst_up_af",      32'(up_af),      32'd0);
      check("rst_up_wrusedw", 32'(up_wrusedw), 32'd0);
      check("rst_up_ovf",     32'(up_ovf),     32'd0);
      check("rst_dn_rdempty", 32'(dn_rdempty), 32'd1);
      check("rst_dn_rdusedw", 32'(dn_rdusedw), 32'd0);
      check("rst_dn_rdata",   32'(dn_rdata),   32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Three bytes are not a read word; the fourth completes one.
      up_wr(8'h11); check("t1_empty_11", 32'(up_rdempty), 32'd1);
      up_wr(8'h22);
      up_wr(8'h33); check("t1_empty_33", 32'(up_rdempty), 32'd1);
      up_wr(8'h44);
      check("t1_rdempty", 32'(up_rdempty), 32'd0);
      check("t1_rdata",   up_rdata,        32'h44332211);
      check("t1_rdusedw", 32'(up_rdusedw), 32'd1);
      check("t1_wrusedw", 32'(up_wrusedw), 32'd4);

      // Fill to 16 bytes, then overflow.
      for (int i = 5; i <= 16; i++) up_wr(8'(8'h11 * i));
      check("t2_wrfull",  32'(up_wrfull),  32'd1);
      check("t2_wrusedw", 32'(up_wrusedw), 32'd16);
      check("t2_af",      32'(up_af),      32'd1);
      check("t2_ovf_pre", 32'(up_ovf),     32'd0);
      up_wr(8'hEE);
      check("t2_ovf",     32'(up_ovf),     32'd1);
      check("t2_rdata",   up_rdata,        32'h44332211);

      // Full with simultaneous read and write: write dropped, read taken.
      step(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("t3_ovf",     32'(up_ovf),     32'd1);
      check("t3_rdusedw", 32'(up_rdusedw), 32'd3);
      check("t3_wrusedw", 32'(up_wrusedw), 32'd12);
      check("t3_rdata",   up_rdata,        32'h88776655);
      repeat (3) up_rd();
      check("t3_drained", 32'(up_rdempty), 32'd1);
      up_rd();
      check("t3_udf",     32'(up_udf),     32'd1);

      // Downsize lane order.
      dn_exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      dn_wr(32'hA1B2C3D4);
      check("t4_rdusedw", 32'(dn_rdusedw), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t4_rdata", 32'(dn_rdata), 32'(dn_exp[i]));
         dn_rd();
      end
      check("t4_rdempty", 32'(dn_rdempty), 32'd1);
      dn_rd();
      check("t4_udf",     32'(dn_udf),     32'd1);

      // Partial-word flush.
      up_wr(8'h55);
      up_wr(8'h66);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (FLUSH_ON) begin
         check("t5_rdata",   up_rdata,        32'h00006655);
         check("t5_wrusedw", 32'(up_wrusedw), 32'd4);
      end else begin
         check("t5_noflush_wrusedw", 32'(up_wrusedw), 32'd2);
         check("t5_noflush_rdempty", 32'(up_rdempty), 32'd1);
      end
      up_rd();

      // Two words stored, reset asserted between edges while a write is pending.
      for (int i = 1; i <= 8; i++) up_wr(8'(i));
      dn_wr(32'h0BADF00D);
      up_wrreq = 1'b1;
      up_wdata = 8'hFF;
      #2 rst = 1'b1;
      chk_en = 1'b0;
      model_reset();
      #1;
      check("t6_up_rdempty", 32'(up_rdempty), 32'd1);
      check("t6_up_wrusedw", 32'(up_wrusedw), 32'd0);
      check("t6_up_rdusedw", 32'(up_rdusedw), 32'd0);
      check("t6_up_ovf",     32'(up_ovf),     32'd0);
      check("t6_up_udf",     32'(up_udf),     32'd0);
      check("t6_dn_udf",     32'(dn_udf),     32'd0);
      check("t6_dn_rdata",   32'(dn_rdata),   32'd0);
      @(negedge clk);
      rst      = 1'b0;
      up_wrreq = 1'b0;
      chk_en   = 1'b1;
      up_wr(8'hAA); up_wr(8'hBB); up_wr(8'hCC); up_wr(8'hDD);
      check("t6_restart_rdata", up_rdata, 32'hDDCCBBAA);

      // Randomised traffic: write-heavy then read-heavy so both boundaries are visited.
      for (int c = 0; c < 800; c++) begin
         if (c < 400)
            step($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 70);
         else
            step($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 15, $urandom, $urandom_range(0, 99) < 80);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
